// File: rtl/wfg_stim_mem.sv
`default_nettype none
// ============================================================================
// Module   : wfg_stim_mem
// Purpose  : Memory-playback stimulus source. Reads 32-bit samples from an
//            external single-port SRAM over [cfg_start, cfg_end] in steps of
//            cfg_inc, scales each one by an unsigned Q8.8 gain and presents
//            the result on an AXI-Stream master port. The pass repeats while
//            enabled; tlast flags the final sample of each pass.
// Ports    : clk, rst_n (async, active-low)
//            ctrl_en_q_i                 - block enable
//            cfg_start/end/inc/gain_q_i  - pass range, step, gain (live)
//            wfg_stim_mem_csb/web/addr_o - SRAM control (read-only use)
//            wfg_stim_mem_dout_i         - SRAM read data
//            wfg_axis_t*                 - AXI-Stream master
// Revision : 1.0 - initial release
// ============================================================================
module wfg_stim_mem #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ctrl_en_q_i,
  input  logic [MEM_ADDR_WIDTH-1:0]  cfg_start_q_i,
  input  logic [MEM_ADDR_WIDTH-1:0]  cfg_end_q_i,
  input  logic [7:0]                 cfg_inc_q_i,
  input  logic [15:0]                cfg_gain_q_i,
  output logic                       wfg_stim_mem_csb_o,
  output logic                       wfg_stim_mem_web_o,
  output logic [MEM_ADDR_WIDTH-1:0]  wfg_stim_mem_addr_o,
  input  logic [31:0]                wfg_stim_mem_dout_i,
  input  logic                       wfg_axis_tready_i,
  output logic                       wfg_axis_tvalid_o,
  output logic                       wfg_axis_tlast_o,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o
);

  localparam int SUM_W = MEM_ADDR_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  logic [1:0]                 state_q,    state_d;
  logic [MEM_ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic                       is_last_q,  is_last_d;
  logic                       csb_q,      csb_d;
  logic [MEM_ADDR_WIDTH-1:0]  addr_q,     addr_d;
  logic                       tvalid_q,   tvalid_d;
  logic                       tlast_q,    tlast_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q,    tdata_d;

  logic [7:0]                w_inc;
  logic [MEM_ADDR_WIDTH-1:0] w_next_addr;
  logic [47:0]               w_prod;

  // A zero increment would stall on one address forever; treat it as 1.
  assign w_inc = (cfg_inc_q_i == 8'd0) ? 8'd1 : cfg_inc_q_i;

  // The pass ends once the following address would exceed cfg_end. The sum
  // carries one extra bit so stepping past the top of memory counts as "past
  // the end" instead of wrapping to a low address.
  function automatic logic last_after(input logic [MEM_ADDR_WIDTH-1:0] a,
                                      input logic [7:0]                inc,
                                      input logic [MEM_ADDR_WIDTH-1:0] e);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(inc);
    return s > {1'b0, e};
  endfunction

  // Truncation is harmless: the truncated sum is only used when not last.
  assign w_next_addr = is_last_q ? cfg_start_q_i
                                 : cur_addr_q + MEM_ADDR_WIDTH'(w_inc);

  assign w_prod = 48'(wfg_stim_mem_dout_i) * 48'(cfg_gain_q_i);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    is_last_d  = is_last_q;
    csb_d      = csb_q;
    addr_d     = addr_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;

    unique case (state_q)
      ST_IDLE: begin
        cur_addr_d = cfg_start_q_i;
        if (ctrl_en_q_i) begin
          csb_d     = 1'b0;
          addr_d    = cfg_start_q_i;
          is_last_d = last_after(cfg_start_q_i, w_inc, cfg_end_q_i);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // SRAM data for the read issued last edge is valid now.
        csb_d    = 1'b1;
        tdata_d  = AXIS_DATA_WIDTH'(w_prod >> 8);
        tlast_d  = is_last_q;
        tvalid_d = 1'b1;
        state_d  = ST_VALID;
      end
      ST_VALID: begin
        if (tvalid_q && wfg_axis_tready_i) begin
          cur_addr_d = w_next_addr;
          tvalid_d   = 1'b0;
          if (ctrl_en_q_i) begin
            // Reissue on the handshake edge for one beat every two cycles.
            csb_d     = 1'b0;
            addr_d    = w_next_addr;
            is_last_d = last_after(w_next_addr, w_inc, cfg_end_q_i);
            state_d   = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins over everything, including a concurrent handshake.
    if (!ctrl_en_q_i) begin
      state_d    = ST_IDLE;
      tvalid_d   = 1'b0;
      tlast_d    = 1'b0;
      csb_d      = 1'b1;
      cur_addr_d = cfg_start_q_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      is_last_q  <= 1'b0;
      csb_q      <= 1'b1;
      addr_q     <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      is_last_q  <= is_last_d;
      csb_q      <= csb_d;
      addr_q     <= addr_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
    end
  end

  assign wfg_stim_mem_csb_o  = csb_q;
  assign wfg_stim_mem_web_o  = 1'b1;
  assign wfg_stim_mem_addr_o = addr_q;
  assign wfg_axis_tvalid_o   = tvalid_q;
  assign wfg_axis_tlast_o    = tlast_q;
  assign wfg_axis_tdata_o    = tdata_q;

endmodule
`default_nettype wire
